// File: rtl/mux_pkg.sv
// Shared constants for the N-channel registered multiplexer (mode codes, counter sizing).
package mux_pkg;

  localparam logic MODO_FIXO = 1'b0;
  localparam logic MODO_RR   = 1'b1;

  localparam int              CONT_W   = 16;
  localparam logic [CONT_W-1:0] CONT_MAX = 16'hFFFF;

  // Round-robin pointer successor: the channel after the last winner, wrapping at n.
  function automatic int ptr_seguinte(input int g, input int n);
    return (g == n - 1) ? 0 : g + 1;
  endfunction

endpackage

// File: rtl/rr_arbitro_n.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping at N.
module rr_arbitro_n
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  localparam int SEL_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [SEL_W-1:0] ptr,
  output logic             gnt_valid,
  output logic [SEL_W-1:0] gnt_idx
);

  int idx;

  // Scan from the farthest offset down so the nearest requester to ptr is assigned last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_n_para_1_rr.sv
// N-channel, W-bit registered multiplexer with fixed-select and round-robin modes.
// Optional per-channel saturating transfer counters when MUX_N_CONTADOR_EN is defined.
module mux_n_para_1_rr
  import mux_pkg::*;
#(
  parameter  int N_CANAIS = 4,
  parameter  int LARGURA  = 8,
  localparam int SEL_W    = $clog2(N_CANAIS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_CANAIS*LARGURA-1:0]   in_data,
  input  logic [N_CANAIS-1:0]           in_valid,
  output logic [N_CANAIS-1:0]           in_ready,
  input  logic                          modo,
  input  logic [SEL_W-1:0]              sel,
  output logic [LARGURA-1:0]            out_data,
  output logic [SEL_W-1:0]              out_canal,
  output logic                          out_valid,
  input  logic                          out_ready
`ifdef MUX_N_CONTADOR_EN
  ,output logic [N_CANAIS*CONT_W-1:0]   contagem
`endif
);

  // Handshake: a beat moves on any edge where valid and ready are both high on the
  // same channel; ready never depends on a beat being accepted later, and a producer
  // must hold valid/data until it sees ready. The output register pops on out_valid &
  // out_ready and may be reloaded in that same cycle.

  localparam int N_EXT = 1 << SEL_W;

  logic             load_en;
  logic             xfer;
  logic             rr_valid;
  logic [SEL_W-1:0] rr_idx;
  logic             fixo_valid;
  logic             gnt_valid;
  logic [SEL_W-1:0] gnt_idx;
  logic [SEL_W-1:0] ptr;
  logic [N_EXT-1:0] valid_ext;
  logic [LARGURA-1:0] dado_sel;

  rr_arbitro_n #(.N(N_CANAIS)) u_rr (
    .req       (in_valid),
    .ptr       (ptr),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Zero-extension makes any sel beyond the last channel read as "not valid".
  assign valid_ext  = N_EXT'(in_valid);
  assign fixo_valid = valid_ext[sel];

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (modo == MODO_RR) begin
      gnt_valid = rr_valid;
      gnt_idx   = rr_idx;
    end else begin
      gnt_valid = fixo_valid;
      gnt_idx   = sel;
    end
  end

  assign load_en  = !out_valid || out_ready;
  assign xfer     = load_en && gnt_valid;
  assign in_ready = xfer ? (N_CANAIS'(1) << gnt_idx) : '0;
  assign dado_sel = in_data[gnt_idx*LARGURA +: LARGURA];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_canal <= '0;
    end else if (load_en) begin
      out_valid <= gnt_valid;
      if (gnt_valid) begin
        out_data  <= dado_sel;
        out_canal <= gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (xfer && modo == MODO_RR) begin
      ptr <= SEL_W'(ptr_seguinte(int'(gnt_idx), N_CANAIS));
    end
  end

`ifdef MUX_N_CONTADOR_EN
  for (genvar i = 0; i < N_CANAIS; i++) begin : g_cont
    logic [CONT_W-1:0] cont;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cont <= '0;
      end else if (in_valid[i] && in_ready[i] && cont != CONT_MAX) begin
        cont <= cont + 1'b1;
      end
    end

    assign contagem[i*CONT_W +: CONT_W] = cont;
  end
`endif

endmodule
